ibex_multdiv_arbiter: RTL and testbench
=======================================

IBEX_MULTDIV_ARBITER -- requirements
Module: ibex_multdiv_arbiter

Interface
REQ-001 The module SHALL have parameter NumReq, default 2, giving the number of requesters sharing one multdiv unit (range 2..4).
REQ-002 The module SHALL have parameter MaxCycles, default 40, giving the watchdog limit in RUN cycles (range 2..255).
REQ-003 The module SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-005 The module SHALL have port req_valid_i, input, NumReq, per-requester request valid.
REQ-006 The module SHALL have port req_ready_o, output, NumReq, per-requester accept, one-hot or zero.
REQ-007 The module SHALL have port req_op_i, input, NumReq x 2, ibex_pkg::md_op_e (0 MULL, 1 MULH, 2 DIV, 3 REM).
REQ-008 The module SHALL have port req_signed_i, input, NumReq x 2, signed mode per operand.
REQ-009 The module SHALL have ports req_op_a_i and req_op_b_i, input, NumReq x 32 each, the operands.
REQ-010 The module SHALL have port kill_i, input, NumReq, per-requester flush.
REQ-011 The module SHALL have ports rsp_valid_o, output, 1; rsp_id_o, output, clog2(NumReq); rsp_result_o, output, 32; and rsp_ready_i, input, 1.
REQ-012 The module SHALL have unit-side outputs md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o (1 each), md_operator_o (2), md_signed_mode_o (2), md_op_a_o and md_op_b_o (32 each), md_ready_id_o (1).
REQ-013 The module SHALL have unit-side inputs md_valid_i (1) and md_result_i (32).
REQ-014 The module SHALL have outputs busy_o (1), state is not IDLE, and timeout_o (1), sticky watchdog error.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, RESP and ABORT.
REQ-016 In IDLE with any req_valid_i high, the arbiter SHALL grant exactly one requester round-robin: the first valid index at or after rr_ptr, wrapping, asserted combinationally on req_ready_o that cycle.
REQ-017 On grant the module SHALL latch id, op, signed mode, op_a and op_b, set rr_ptr to (id+1) mod NumReq, and enter RUN next cycle.
REQ-018 req_ready_o SHALL be all-zero outside IDLE; a grant whose kill_i[id] is high in the same cycle SHALL NOT be issued (that index is masked).
REQ-019 In RUN, md_*_sel_o and md_*_en_o SHALL follow the latched op: mult if op[1]==0, div otherwise; md_ready_id_o=1; operand and operator outputs SHALL be the latched values, stable for the whole RUN.
REQ-020 In RUN, when md_valid_i=1, the module SHALL latch md_result_i and enter RESP; minimum grant-to-rsp_valid latency is 2 cycles.
REQ-021 In RESP, rsp_valid_o=1 with latched result and id, held stable until rsp_ready_i=1; then go to IDLE.
REQ-022 kill_i[id] in RUN SHALL take ABORT; in RESP SHALL drop the response (rsp_valid_o low next cycle) and go to IDLE; kill_i for non-owning indices SHALL be ignored.
REQ-023 ABORT SHALL last exactly one cycle with all md_*_en_o, md_*_sel_o and md_ready_id_o at 0, then go to IDLE.
REQ-024 A RUN cycle counter SHALL clear on entry to RUN and increment each RUN cycle; if it reaches MaxCycles without md_valid_i, timeout_o SHALL set and the FSM SHALL take ABORT.
REQ-025 md_valid_i and kill_i[id] in the same RUN cycle SHALL take kill priority (ABORT, no response).
REQ-026 md_valid_i SHALL be ignored outside RUN.
REQ-027 Outside RUN, all md_* outputs SHALL be 0.

Reset
REQ-028 With rst_ni=0 at a rising edge, the module SHALL go to IDLE with rr_ptr=0, counter=0, timeout_o=0, and all latched data 0.
REQ-029 During and after reset, req_ready_o, rsp_valid_o, busy_o and all md_* outputs SHALL be 0; reset mid-RUN or mid-RESP SHALL abandon the operation with no response.
REQ-030 timeout_o SHALL be cleared only by reset.

Verification
REQ-031 Requester 0 MULL a=7, b=6, unit returns valid after 3 cycles with 42 -> rsp_valid_o=1, rsp_id_o=0, rsp_result_o=42; busy_o low the cycle after rsp_ready_i.
REQ-032 Both requesters valid continuously, DIV 100/7 and REM 100/7 -> grants alternate 0,1,0,1; results 14 and 2 tagged with the correct id.
REQ-033 kill_i[0] in the second RUN cycle -> one ABORT cycle with en/sel=0, no rsp_valid_o, and requester 1 granted in the following IDLE.
REQ-034 md_valid_i never asserted -> after 40 RUN cycles timeout_o=1 and the FSM aborts; the next request completes normally with timeout_o still 1.
REQ-035 rsp_ready_i held low 5 cycles in RESP -> rsp_result_o and rsp_id_o stable, req_ready_o=0 throughout.
REQ-036 rst_ni=0 for one cycle mid-RUN -> next cycle all outputs 0, rr_ptr=0, and requester 0 wins the first subsequent contention.

Source files
------------

// File: rtl/ibex_multdiv_arbiter.sv
// ibex_multdiv_arbiter
//
// Shares a single multiply/divide unit between NumReq requesters. A
// round-robin arbiter grants one request at a time while idle. The operation
// is latched and presented to the unit until it returns a result. The result
// is then held on the response port until it is accepted. Every operation
// runs under a watchdog; if it fires, the operation is abandoned and a
// sticky timeout flag is raised.
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   req_valid_i/ready_o     per-requester handshake (ready is one-hot or zero)
//   req_op_i, req_signed_i  per-requester operator / signed mode, 2 bits each,
//                           flattened (requester i at [2*i +: 2])
//   req_op_a_i, req_op_b_i  per-requester operands, 32 bits each, flattened
//   kill_i                  per-requester flush of its in-flight operation
//   rsp_valid_o/ready_i     response handshake, rsp_id_o tags the owner
//   rsp_result_o            result returned by the unit
//   md_*_o                  drive the shared multdiv unit (zero unless running)
//   md_valid_i, md_result_i completion and result from the unit
//   busy_o                  an operation is in flight (FSM not idle)
//   timeout_o               sticky watchdog error, cleared only by reset
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no operation; arbitrate among valid, non-killed requesters
// RUN   | latched operation driven to the unit, watchdog counting
// RESP  | result held on rsp_* until accepted or the owner is killed
// ABORT | one quiet cycle after a kill or a timeout, unit outputs low

module ibex_multdiv_arbiter #(
    parameter int NumReq    = 2,
    parameter int MaxCycles = 40
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [NumReq-1:0]         req_valid_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  logic [2*NumReq-1:0]       req_op_i,
    input  logic [2*NumReq-1:0]       req_signed_i,
    input  logic [32*NumReq-1:0]      req_op_a_i,
    input  logic [32*NumReq-1:0]      req_op_b_i,
    input  logic [NumReq-1:0]         kill_i,

    output logic                      rsp_valid_o,
    output logic [$clog2(NumReq)-1:0] rsp_id_o,
    output logic [31:0]               rsp_result_o,
    input  logic                      rsp_ready_i,

    output logic                      md_mult_en_o,
    output logic                      md_div_en_o,
    output logic                      md_mult_sel_o,
    output logic                      md_div_sel_o,
    output logic [1:0]                md_operator_o,
    output logic [1:0]                md_signed_mode_o,
    output logic [31:0]               md_op_a_o,
    output logic [31:0]               md_op_b_o,
    output logic                      md_ready_id_o,
    input  logic                      md_valid_i,
    input  logic [31:0]               md_result_i,

    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IdW = $clog2(NumReq);
    localparam logic [7:0] LastCnt = 8'(MaxCycles - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q;
    logic [IdW-1:0]   id_q;
    logic [1:0]       op_q;
    logic [1:0]       sgn_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      result_q;
    logic [7:0]       cnt_q;
    logic             timeout_q;

    logic [1:0]       op_arr  [NumReq];
    logic [1:0]       sgn_arr [NumReq];
    logic [31:0]      a_arr   [NumReq];
    logic [31:0]      b_arr   [NumReq];

    logic [NumReq-1:0] eligible;
    logic              grant_found;
    logic [IdW-1:0]    grant_id;
    logic [IdW:0]      cand_sum;
    logic [IdW:0]      next_sum;
    logic [IdW-1:0]    rr_next;
    logic              kill_own;
    logic              timeout_set;
    logic              result_load;

    // Unflatten the per-requester buses so the granted slot can be indexed
    // directly by grant_id.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            op_arr[i]  = req_op_i[2*i +: 2];
            sgn_arr[i] = req_signed_i[2*i +: 2];
            a_arr[i]   = req_op_a_i[32*i +: 32];
            b_arr[i]   = req_op_b_i[32*i +: 32];
        end
    end

    // A requester being killed in the same cycle is not eligible for a grant.
    // Nothing is granted while reset is held.
    assign eligible = (rst_ni && state_q == IDLE) ? (req_valid_i & ~kill_i)
                                                  : '0;

    // Round-robin: first eligible index at or after rr_ptr_q, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_sum    = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IdW+1)'(k);
            if (cand_sum >= (IdW+1)'(NumReq)) begin
                cand_sum = cand_sum - (IdW+1)'(NumReq);
            end
            if (!grant_found && eligible[cand_sum[IdW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand_sum[IdW-1:0];
            end
        end
    end

    always_comb begin
        next_sum = {1'b0, grant_id} + (IdW+1)'(1);
        if (next_sum >= (IdW+1)'(NumReq)) begin
            next_sum = '0;
        end
        rr_next = next_sum[IdW-1:0];
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = grant_found && (grant_id == IdW'(i));
        end
    end

    assign kill_own = kill_i[id_q];

    // Next-state logic. Within RUN, a kill of the owner beats a completing
    // unit, and a completing unit beats the watchdog.
    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        result_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (kill_own) begin
                    state_d = ABORT;
                end else if (md_valid_i) begin
                    state_d     = RESP;
                    result_load = 1'b1;
                end else if (cnt_q == LastCnt) begin
                    state_d     = ABORT;
                    timeout_set = 1'b1;
                end
            end
            RESP: begin
                if (kill_own || rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. Everything is forced low while reset is asserted, even before
    // the first reset edge has settled the state register.
    always_comb begin
        busy_o           = 1'b0;
        rsp_valid_o      = 1'b0;
        md_mult_en_o     = 1'b0;
        md_div_en_o      = 1'b0;
        md_mult_sel_o    = 1'b0;
        md_div_sel_o     = 1'b0;
        md_operator_o    = 2'b00;
        md_signed_mode_o = 2'b00;
        md_op_a_o        = 32'd0;
        md_op_b_o        = 32'd0;
        md_ready_id_o    = 1'b0;
        if (rst_ni) begin
            busy_o = (state_q != IDLE);
            if (state_q == RUN) begin
                // op[1] separates DIV/REM from MULL/MULH.
                md_mult_en_o     = ~op_q[1];
                md_mult_sel_o    = ~op_q[1];
                md_div_en_o      = op_q[1];
                md_div_sel_o     = op_q[1];
                md_operator_o    = op_q;
                md_signed_mode_o = sgn_q;
                md_op_a_o        = a_q;
                md_op_b_o        = b_q;
                md_ready_id_o    = 1'b1;
            end
            if (state_q == RESP) begin
                rsp_valid_o = 1'b1;
            end
        end
    end

    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign timeout_o    = timeout_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            op_q      <= 2'b00;
            sgn_q     <= 2'b00;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            result_q  <= 32'd0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_found) begin
                id_q     <= grant_id;
                op_q     <= op_arr[grant_id];
                sgn_q    <= sgn_arr[grant_id];
                a_q      <= a_arr[grant_id];
                b_q      <= b_arr[grant_id];
                rr_ptr_q <= rr_next;
                cnt_q    <= 8'd0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (result_load) begin
                result_q <= md_result_i;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter with NumReq=2, MaxCycles=40.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
module tb_ibex_multdiv_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [3:0]  req_op_i;
    logic [3:0]  req_signed_i;
    logic [63:0] req_op_a_i;
    logic [63:0] req_op_b_i;
    logic [1:0]  kill_i;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [31:0] rsp_result_o;
    logic        rsp_ready_i;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic        md_mult_sel_o;
    logic        md_div_sel_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic        md_ready_id_o;
    logic        md_valid_i;
    logic [31:0] md_result_i;
    logic        busy_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    ibex_multdiv_arbiter #(.NumReq(2), .MaxCycles(40)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_signed_i     (req_signed_i),
        .req_op_a_i       (req_op_a_i),
        .req_op_b_i       (req_op_b_i),
        .kill_i           (kill_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_id_o         (rsp_id_o),
        .rsp_result_o     (rsp_result_o),
        .rsp_ready_i      (rsp_ready_i),
        .md_mult_en_o     (md_mult_en_o),
        .md_div_en_o      (md_div_en_o),
        .md_mult_sel_o    (md_mult_sel_o),
        .md_div_sel_o     (md_div_sel_o),
        .md_operator_o    (md_operator_o),
        .md_signed_mode_o (md_signed_mode_o),
        .md_op_a_o        (md_op_a_o),
        .md_op_b_o        (md_op_b_o),
        .md_ready_id_o    (md_ready_id_o),
        .md_valid_i       (md_valid_i),
        .md_result_i      (md_result_i),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Full transaction starting in IDLE with the request already driven:
    // grant now, unit completes on RUN cycle 'lat', response held 'hold'
    // extra cycles before being accepted.
    task automatic run_txn(input int id, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input int hold,
                           input logic [31:0] res);
        logic [1:0] one_hot;
        one_hot = 2'b01 << id;
        settle();
        chk("grant", {30'd0, req_ready_o}, {30'd0, one_hot});
        tick();
        settle();
        chk("run_busy", {31'd0, busy_o}, 32'd1);
        chk("run_op", {30'd0, md_operator_o}, {30'd0, op});
        chk("run_a", md_op_a_o, a);
        chk("run_b", md_op_b_o, b);
        chk("run_div_en", {31'd0, md_div_en_o}, {31'd0, op[1]});
        chk("run_div_sel", {31'd0, md_div_sel_o}, {31'd0, op[1]});
        chk("run_mult_en", {31'd0, md_mult_en_o}, {31'd0, ~op[1]});
        chk("run_mult_sel", {31'd0, md_mult_sel_o}, {31'd0, ~op[1]});
        chk("run_ready_id", {31'd0, md_ready_id_o}, 32'd1);
        chk("run_no_grant", {30'd0, req_ready_o}, 32'd0);
        for (int c = 1; c < lat; c++) begin
            tick();
            settle();
            chk("run_rsp_low", {31'd0, rsp_valid_o}, 32'd0);
            chk("run_a_stable", md_op_a_o, a);
        end
        md_valid_i  = 1'b1;
        md_result_i = res;
        tick();
        md_valid_i  = 1'b0;
        md_result_i = 32'hdead_beef;
        settle();
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("hold_id", {31'd0, rsp_id_o}, id);
            chk("hold_result", rsp_result_o, res);
            chk("hold_no_grant", {30'd0, req_ready_o}, 32'd0);
            tick();
            settle();
        end
        chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("rsp_id", {31'd0, rsp_id_o}, id);
        chk("rsp_result", rsp_result_o, res);
        chk("rsp_md_off", {31'd0, md_mult_en_o | md_div_en_o}, 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        settle();
        chk("after_busy", {31'd0, busy_o}, 32'd0);
        chk("after_rsp_low", {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 2'b11;
        req_op_i     = 4'd0;
        req_signed_i = 4'd0;
        req_op_a_i   = 64'd0;
        req_op_b_i   = 64'd0;
        kill_i       = 2'b00;
        rsp_ready_i  = 1'b0;
        md_valid_i   = 1'b0;
        md_result_i  = 32'd0;

        // Reset with requests pending
        tick();
        tick();
        settle();
        chk("rst_ready", {30'd0, req_ready_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        chk("rst_md_en", {31'd0, md_mult_en_o | md_div_en_o}, 32'd0);
        chk("rst_ready_id", {31'd0, md_ready_id_o}, 32'd0);

        // Two requesters contending continuously: DIV from 0, REM from 1
        req_op_i   = {2'd3, 2'd2};
        req_op_a_i = {32'd100, 32'd100};
        req_op_b_i = {32'd7, 32'd7};
        rst_ni     = 1'b1;
        run_txn(0, 2'd2, 32'd100, 32'd7, 1, 0, 32'd14);
        run_txn(1, 2'd3, 32'd100, 32'd7, 2, 0, 32'd2);
        run_txn(0, 2'd2, 32'd100, 32'd7, 1, 0, 32'd14);
        run_txn(1, 2'd3, 32'd100, 32'd7, 3, 0, 32'd2);

        // Requester 0 alone, MULL 7*6, unit answers on the third RUN cycle
        req_valid_i = 2'b01;
        req_op_i    = {2'd3, 2'd0};
        req_op_a_i  = {32'd100, 32'd7};
        req_op_b_i  = {32'd7, 32'd6};
        run_txn(0, 2'd0, 32'd7, 32'd6, 3, 0, 32'd42);
        req_valid_i = 2'b00;

        // Unit completion while idle is ignored
        md_valid_i  = 1'b1;
        md_result_i = 32'd99;
        tick();
        md_valid_i = 1'b0;
        settle();
        chk("idle_mdv_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_mdv_rsp", {31'd0, rsp_valid_o}, 32'd0);

        // A killed requester is not granted
        req_valid_i = 2'b01;
        kill_i      = 2'b01;
        settle();
        chk("kill_mask", {30'd0, req_ready_o}, 32'd0);
        tick();
        settle();
        chk("kill_mask_busy", {31'd0, busy_o}, 32'd0);
        kill_i      = 2'b00;
        req_valid_i = 2'b00;

        // Response stalled for 5 cycles; requester 1 wins (pointer at 1)
        req_valid_i = 2'b11;
        req_op_i    = {2'd1, 2'd0};
        req_op_a_i  = {32'h0001_0000, 32'd5};
        req_op_b_i  = {32'h0001_0000, 32'd5};
        run_txn(1, 2'd1, 32'h0001_0000, 32'h0001_0000, 2, 5, 32'd1);
        req_valid_i = 2'b00;

        // Kill of owner 0 on its second RUN cycle, then requester 1 served
        req_valid_i = 2'b11;
        req_op_i    = {2'd3, 2'd2};
        req_op_a_i  = {32'd100, 32'd100};
        req_op_b_i  = {32'd7, 32'd7};
        settle();
        chk("k_grant0", {30'd0, req_ready_o}, 32'd1);
        tick();
        settle();
        chk("k_run1_div", {31'd0, md_div_en_o}, 32'd1);
        tick();
        kill_i = 2'b01;
        settle();
        chk("k_run2_div", {31'd0, md_div_en_o}, 32'd1);
        tick();
        kill_i = 2'b00;
        settle();
        chk("abort_busy", {31'd0, busy_o}, 32'd1);
        chk("abort_div_en", {31'd0, md_div_en_o}, 32'd0);
        chk("abort_div_sel", {31'd0, md_div_sel_o}, 32'd0);
        chk("abort_mult", {31'd0, md_mult_en_o | md_mult_sel_o}, 32'd0);
        chk("abort_ready_id", {31'd0, md_ready_id_o}, 32'd0);
        chk("abort_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("abort_no_grant", {30'd0, req_ready_o}, 32'd0);
        tick();
        run_txn(1, 2'd3, 32'd100, 32'd7, 1, 0, 32'd2);
        req_valid_i = 2'b00;

        // Kill and completion in the same RUN cycle: kill wins
        req_valid_i = 2'b01;
        settle();
        chk("kv_grant0", {30'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 2'b00;
        md_valid_i  = 1'b1;
        md_result_i = 32'd55;
        kill_i      = 2'b01;
        tick();
        md_valid_i = 1'b0;
        kill_i     = 2'b00;
        settle();
        chk("kv_abort_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("kv_abort_busy", {31'd0, busy_o}, 32'd1);
        tick();
        settle();
        chk("kv_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("kv_idle_rsp", {31'd0, rsp_valid_o}, 32'd0);

        // Kill of a non-owning index is ignored throughout
        req_valid_i = 2'b10;
        kill_i      = 2'b01;
        run_txn(1, 2'd3, 32'd100, 32'd7, 2, 1, 32'd2);
        kill_i      = 2'b00;
        req_valid_i = 2'b00;

        // Watchdog: no completion for 40 RUN cycles
        req_valid_i = 2'b01;
        req_op_i    = {2'd3, 2'd0};
        req_op_a_i  = {32'd100, 32'd1};
        req_op_b_i  = {32'd7, 32'd1};
        settle();
        chk("wd_grant0", {30'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 2'b00;
        repeat (39) tick();
        settle();
        chk("wd_run40_timeout", {31'd0, timeout_o}, 32'd0);
        chk("wd_run40_mult", {31'd0, md_mult_en_o}, 32'd1);
        tick();
        settle();
        chk("wd_abort_timeout", {31'd0, timeout_o}, 32'd1);
        chk("wd_abort_mult", {31'd0, md_mult_en_o}, 32'd0);
        chk("wd_abort_busy", {31'd0, busy_o}, 32'd1);
        chk("wd_abort_rsp", {31'd0, rsp_valid_o}, 32'd0);
        tick();
        settle();
        chk("wd_idle_busy", {31'd0, busy_o}, 32'd0);
        req_valid_i = 2'b01;
        req_op_a_i  = {32'd100, 32'd7};
        req_op_b_i  = {32'd7, 32'd6};
        run_txn(0, 2'd0, 32'd7, 32'd6, 1, 0, 32'd42);
        req_valid_i = 2'b00;
        chk("wd_sticky", {31'd0, timeout_o}, 32'd1);

        // Reset for one cycle in the middle of RUN
        req_valid_i = 2'b01;
        req_op_a_i  = {32'd100, 32'd9};
        req_op_b_i  = {32'd7, 32'd9};
        settle();
        chk("mr_grant0", {30'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 2'b00;
        settle();
        chk("mr_run_busy", {31'd0, busy_o}, 32'd1);
        rst_ni      = 1'b0;
        req_valid_i = 2'b11;
        settle();
        chk("mr_during_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_during_md", {31'd0, md_mult_en_o | md_ready_id_o}, 32'd0);
        chk("mr_during_ready", {30'd0, req_ready_o}, 32'd0);
        tick();
        rst_ni      = 1'b1;
        req_valid_i = 2'b00;
        settle();
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_timeout", {31'd0, timeout_o}, 32'd0);
        chk("mr_md_en", {31'd0, md_mult_en_o | md_div_en_o}, 32'd0);
        chk("mr_md_a", md_op_a_o, 32'd0);
        chk("mr_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("mr_rsp_id", {31'd0, rsp_id_o}, 32'd0);
        chk("mr_rsp_result", rsp_result_o, 32'd0);
        req_valid_i = 2'b11;
        req_op_i    = {2'd3, 2'd2};
        req_op_a_i  = {32'd100, 32'd100};
        req_op_b_i  = {32'd7, 32'd7};
        run_txn(0, 2'd2, 32'd100, 32'd7, 1, 0, 32'd14);
        req_valid_i = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
